// File: rtl/spi_pkg.sv
// Shared types and mode helpers for the SPI slave controller.
package spi_pkg;

  localparam int unsigned DefaultDataWidth = 16;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } spi_state_e;

  typedef enum logic [1:0] {
    Mode0,
    Mode1,
    Mode2,
    Mode3
  } spi_mode_e;

  function automatic spi_mode_e to_mode(input logic cpol, input logic cpha);
    return spi_mode_e'({cpol, cpha});
  endfunction

  // Modes 0 and 3 sample MOSI on the rising SCLK edge, modes 1 and 2 on the falling one.
  function automatic logic sample_on_rise(input spi_mode_e mode);
    return (mode == Mode0) || (mode == Mode3);
  endfunction

  function automatic logic shift_on_rise(input spi_mode_e mode);
    return !sample_on_rise(mode);
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop pad synchronizer with a history flop for rise/fall pulse detection.
module spi_edge_sync #(
  parameter int unsigned SyncStages = 2,
  parameter logic        ResetVal   = 1'b0
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic sig_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SyncStages-1:0] sync_q;
  logic                  hist_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= {SyncStages{ResetVal}};
      hist_q <= ResetVal;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], sig_i};
      hist_q <= sync_q[SyncStages-1];
    end
  end

  assign level_o = sync_q[SyncStages-1];
  assign rise_o  = sync_q[SyncStages-1] & ~hist_q;
  assign fall_o  = ~sync_q[SyncStages-1] & hist_q;

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave: oversampled pads, one DATA_WIDTH-bit MSB-first frame per SS-low window,
// single-entry transmit buffer and pulsed receive/error status.
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DefaultDataWidth,
  parameter bit          CLK_POLARITY = 1'b0,
  parameter bit          CLK_PHASE    = 1'b0,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  spi_sclk_i,
  input  logic                  spi_ss_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  spi_miso_oe_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  tx_underrun_o,
  output logic                  frame_err_o,
  output logic                  busy_o
);

  localparam spi_mode_e   Mode       = to_mode(CLK_POLARITY, CLK_PHASE);
  localparam bit          SampleRise = sample_on_rise(Mode);
  localparam bit          ShiftRise  = shift_on_rise(Mode);
  localparam int unsigned CntW       = $clog2(DATA_WIDTH + 1);

  logic sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_s;
  logic unused_sclk_level, unused_ss_level;
  logic [1:0] unused_mosi_edges;

  spi_edge_sync #(.SyncStages(SYNC_STAGES), .ResetVal(CLK_POLARITY)) u_sclk_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .sig_i  (spi_sclk_i),
    .level_o(unused_sclk_level),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_edge_sync #(.SyncStages(SYNC_STAGES), .ResetVal(1'b1)) u_ss_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .sig_i  (spi_ss_i),
    .level_o(unused_ss_level),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  spi_edge_sync #(.SyncStages(SYNC_STAGES), .ResetVal(1'b0)) u_mosi_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .sig_i  (spi_mosi_i),
    .level_o(mosi_s),
    .rise_o (unused_mosi_edges[0]),
    .fall_o (unused_mosi_edges[1])
  );

  logic sample_edge, shift_edge;
  assign sample_edge = SampleRise ? sclk_rise : sclk_fall;
  assign shift_edge  = ShiftRise  ? sclk_rise : sclk_fall;

  spi_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d, tx_sr_q, tx_sr_d, load_word;
  logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d, rx_data_q, rx_data_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  tx_full_q, tx_full_d, miso_q, miso_d;
  logic                  rx_valid_q, rx_valid_d, underrun_q, underrun_d, ferr_q, ferr_d;

  always_comb begin
    state_d    = state_q;
    tx_buf_d   = tx_buf_q;
    tx_full_d  = tx_full_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    cnt_d      = cnt_q;
    miso_d     = miso_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    ferr_d     = 1'b0;
    load_word  = tx_full_q ? tx_buf_q : '0;

    if (tx_valid_i && !tx_full_q) begin
      tx_full_d = 1'b1;
      tx_buf_d  = tx_data_i;
    end

    case (state_q)
      StIdle: begin
        if (ss_fall) begin
          state_d    = StShift;
          cnt_d      = '0;
          rx_sr_d    = '0;
          underrun_d = !tx_full_q;
          if (tx_full_q) tx_full_d = 1'b0;
          // With CPHA=0 the MSB must be on the wire before the first sample edge,
          // so it is driven now and the shift register is pre-advanced by one bit.
          if (CLK_PHASE) begin
            tx_sr_d = load_word;
          end else begin
            tx_sr_d = load_word << 1;
            miso_d  = load_word[DATA_WIDTH-1];
          end
        end
      end
      StShift: begin
        if (ss_rise) begin
          ferr_d  = 1'b1;
          state_d = StIdle;
        end else begin
          if (sample_edge) begin
            rx_sr_d = {rx_sr_q[DATA_WIDTH-2:0], mosi_s};
            cnt_d   = cnt_q + CntW'(1);
            if (cnt_d == CntW'(DATA_WIDTH)) begin
              rx_data_d  = rx_sr_d;
              rx_valid_d = 1'b1;
              state_d    = StDone;
            end
          end
          if (shift_edge) begin
            miso_d  = tx_sr_q[DATA_WIDTH-1];
            tx_sr_d = tx_sr_q << 1;
          end
        end
      end
      StDone: begin
        if (ss_rise) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= StIdle;
      tx_buf_q   <= '0;
      tx_full_q  <= 1'b0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      cnt_q      <= '0;
      miso_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_buf_q   <= tx_buf_d;
      tx_full_q  <= tx_full_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      cnt_q      <= cnt_d;
      miso_q     <= miso_d;
      rx_valid_q <= rx_valid_d;
      underrun_q <= underrun_d;
      ferr_q     <= ferr_d;
    end
  end

  assign spi_miso_o    = miso_q;
  assign spi_miso_oe_o = (state_q != StIdle);
  assign busy_o        = (state_q != StIdle);
  assign tx_ready_o    = !tx_full_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign tx_underrun_o = underrun_q;
  assign frame_err_o   = ferr_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench: a mode-0 and a mode-3 slave driven by a behavioural SPI master.
module tb_spi_slave_ctrl;

  localparam int W    = 16;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rstn;
  logic         sclk [2], ss [2], mosi [2], miso [2], oe [2];
  logic         tx_valid [2], tx_ready [2], rx_valid [2], underrun [2], ferr [2], busy [2];
  logic [W-1:0] tx_data [2], rx_data [2];

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid [2] = '{0, 0};
  int n_under [2] = '{0, 0};
  int n_ferr  [2] = '{0, 0};

  always #5 clk = ~clk;

  spi_slave_ctrl #(.DATA_WIDTH(W), .CLK_POLARITY(1'b0), .CLK_PHASE(1'b0), .SYNC_STAGES(2)) dut0 (
    .clk_i(clk), .rstn_i(rstn), .spi_sclk_i(sclk[0]), .spi_ss_i(ss[0]), .spi_mosi_i(mosi[0]),
    .spi_miso_o(miso[0]), .spi_miso_oe_o(oe[0]), .tx_data_i(tx_data[0]),
    .tx_valid_i(tx_valid[0]), .tx_ready_o(tx_ready[0]), .rx_data_o(rx_data[0]),
    .rx_valid_o(rx_valid[0]), .tx_underrun_o(underrun[0]), .frame_err_o(ferr[0]),
    .busy_o(busy[0])
  );

  spi_slave_ctrl #(.DATA_WIDTH(W), .CLK_POLARITY(1'b1), .CLK_PHASE(1'b1), .SYNC_STAGES(2)) dut3 (
    .clk_i(clk), .rstn_i(rstn), .spi_sclk_i(sclk[1]), .spi_ss_i(ss[1]), .spi_mosi_i(mosi[1]),
    .spi_miso_o(miso[1]), .spi_miso_oe_o(oe[1]), .tx_data_i(tx_data[1]),
    .tx_valid_i(tx_valid[1]), .tx_ready_o(tx_ready[1]), .rx_data_o(rx_data[1]),
    .rx_valid_o(rx_valid[1]), .tx_underrun_o(underrun[1]), .frame_err_o(ferr[1]),
    .busy_o(busy[1])
  );

  // Cycle counts of each pulse output; a clean one-cycle pulse adds exactly one.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rx_valid[i] === 1'b1) n_valid[i]++;
      if (underrun[i] === 1'b1) n_under[i]++;
      if (ferr[i] === 1'b1) n_ferr[i]++;
    end
  end

  task automatic push(input int idx, input logic [W-1:0] d);
    int k;
    k = 0;
    @(negedge clk);
    tx_data[idx]  = d;
    tx_valid[idx] = 1'b1;
    while (tx_ready[idx] !== 1'b1 && k < 500) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (k >= 500) begin
      n_fail++;
      $display("FAIL push_timeout[%0d]: tx_ready=%b required 1", idx, tx_ready[idx]);
    end
    @(negedge clk);
    tx_valid[idx] = 1'b0;
  endtask

  // Master for dut idx (0: CPOL=0/CPHA=0, 1: CPOL=1/CPHA=1); sends nbits MSB first.
  task automatic xfer(input int idx, input logic [W-1:0] tx, input int nbits,
                      output logic [W-1:0] rx);
    logic cpol, cpha;
    cpol = (idx == 1);
    cpha = (idx == 1);
    rx   = '0;
    @(negedge clk);
    ss[idx] = 1'b0;
    if (!cpha) mosi[idx] = tx[W-1];
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (cpha) mosi[idx] = tx[W-1-i];
      else rx[W-1-i] = miso[idx];
      sclk[idx] = ~cpol;
      repeat (HALF) @(negedge clk);
      if (cpha) rx[W-1-i] = miso[idx];
      else if (i < W - 1) mosi[idx] = tx[W-2-i];
      sclk[idx] = cpol;
      repeat (HALF) @(negedge clk);
    end
    ss[idx] = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      n_tests += 5;
      if (miso[i] !== 1'b0 || oe[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_miso[%0d]: miso=%b oe=%b required 0 0", i, miso[i], oe[i]);
      end
      if (tx_ready[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_tx_ready[%0d]: got %b required 1", i, tx_ready[i]);
      end
      if (rx_data[i] !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_rx_data[%0d]: got %h required 0000", i, rx_data[i]);
      end
      if (rx_valid[i] !== 1'b0 || underrun[i] !== 1'b0 || ferr[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_pulses[%0d]: got %b%b%b required 000", i, rx_valid[i],
                 underrun[i], ferr[i]);
      end
      if (busy[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_busy[%0d]: got %b required 0", i, busy[i]);
      end
    end
  endtask

  task automatic test_mode0();
    logic [W-1:0] rd;
    int v0, u0;
    push(0, 16'h1234);
    n_tests++;
    if (tx_ready[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mode0_ready_after_push: got %b required 0", tx_ready[0]);
    end
    v0 = n_valid[0];
    u0 = n_under[0];
    xfer(0, 16'hA5C3, W, rd);
    n_tests += 6;
    if (rd !== 16'h1234) begin
      n_fail++;
      $display("FAIL mode0_miso: got %h required 1234", rd);
    end
    if (rx_data[0] !== 16'hA5C3) begin
      n_fail++;
      $display("FAIL mode0_rx_data: got %h required a5c3", rx_data[0]);
    end
    if (n_valid[0] - v0 !== 1) begin
      n_fail++;
      $display("FAIL mode0_rx_valid_cycles: got %0d required 1", n_valid[0] - v0);
    end
    if (n_under[0] - u0 !== 0) begin
      n_fail++;
      $display("FAIL mode0_underrun: got %0d required 0", n_under[0] - u0);
    end
    if (busy[0] !== 1'b0 || oe[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mode0_idle_after: busy=%b oe=%b required 0 0", busy[0], oe[0]);
    end
    if (tx_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL mode0_ready_after_frame: got %b required 1", tx_ready[0]);
    end
  endtask

  task automatic test_mode3();
    logic [W-1:0] rd;
    int v0;
    push(1, 16'h8001);
    v0 = n_valid[1];
    xfer(1, 16'h7FFE, W, rd);
    n_tests += 3;
    if (rd !== 16'h8001) begin
      n_fail++;
      $display("FAIL mode3_miso: got %h required 8001", rd);
    end
    if (rx_data[1] !== 16'h7FFE) begin
      n_fail++;
      $display("FAIL mode3_rx_data: got %h required 7ffe", rx_data[1]);
    end
    if (n_valid[1] - v0 !== 1) begin
      n_fail++;
      $display("FAIL mode3_rx_valid_cycles: got %0d required 1", n_valid[1] - v0);
    end
  endtask

  task automatic test_underrun();
    logic [W-1:0] rd;
    int v0, u0;
    v0 = n_valid[0];
    u0 = n_under[0];
    xfer(0, 16'hFFFF, W, rd);
    n_tests += 4;
    if (rd !== 16'h0000) begin
      n_fail++;
      $display("FAIL underrun_miso: got %h required 0000", rd);
    end
    if (rx_data[0] !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL underrun_rx_data: got %h required ffff", rx_data[0]);
    end
    if (n_under[0] - u0 !== 1) begin
      n_fail++;
      $display("FAIL underrun_pulse_cycles: got %0d required 1", n_under[0] - u0);
    end
    if (n_valid[0] - v0 !== 1) begin
      n_fail++;
      $display("FAIL underrun_rx_valid_cycles: got %0d required 1", n_valid[0] - v0);
    end
  endtask

  task automatic test_abort();
    logic [W-1:0] rd;
    int v0, f0;
    v0 = n_valid[0];
    f0 = n_ferr[0];
    xfer(0, 16'h1234, 9, rd);
    n_tests += 4;
    if (n_ferr[0] - f0 !== 1) begin
      n_fail++;
      $display("FAIL abort_frame_err_cycles: got %0d required 1", n_ferr[0] - f0);
    end
    if (n_valid[0] - v0 !== 0) begin
      n_fail++;
      $display("FAIL abort_rx_valid_cycles: got %0d required 0", n_valid[0] - v0);
    end
    if (rx_data[0] !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL abort_rx_data_kept: got %h required ffff", rx_data[0]);
    end
    if (busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_busy: got %b required 0", busy[0]);
    end
    v0 = n_valid[0];
    f0 = n_ferr[0];
    xfer(0, 16'h00FF, W, rd);
    n_tests += 3;
    if (rx_data[0] !== 16'h00FF) begin
      n_fail++;
      $display("FAIL abort_next_rx_data: got %h required 00ff", rx_data[0]);
    end
    if (n_valid[0] - v0 !== 1) begin
      n_fail++;
      $display("FAIL abort_next_rx_valid_cycles: got %0d required 1", n_valid[0] - v0);
    end
    if (n_ferr[0] - f0 !== 0) begin
      n_fail++;
      $display("FAIL abort_next_frame_err: got %0d required 0", n_ferr[0] - f0);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] r1, r2;
    push(0, 16'h1111);
    fork
      xfer(0, 16'h0F0F, W, r1);
      begin
        repeat (60) @(negedge clk);
        n_tests++;
        if (busy[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_busy_mid_frame: got %b required 1", busy[0]);
        end
        push(0, 16'hBEEF);
      end
    join
    n_tests += 2;
    if (r1 !== 16'h1111) begin
      n_fail++;
      $display("FAIL b2b_frame1_miso: got %h required 1111", r1);
    end
    if (tx_ready[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ready_held: got %b required 0", tx_ready[0]);
    end
    xfer(0, 16'hF0F0, W, r2);
    n_tests += 3;
    if (r2 !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL b2b_frame2_miso: got %h required beef", r2);
    end
    if (rx_data[0] !== 16'hF0F0) begin
      n_fail++;
      $display("FAIL b2b_frame2_rx_data: got %h required f0f0", rx_data[0]);
    end
    if (tx_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready_after: got %b required 1", tx_ready[0]);
    end
  endtask

  task automatic test_reset_midframe();
    logic [W-1:0] rd;
    int v0, u0, f0;
    push(0, 16'h7777);
    fork
      xfer(0, 16'h1234, W, rd);
      begin
        repeat (HALF + 6 * 2 * HALF + 2) @(negedge clk);
        rstn = 1'b0;
        #1;
        n_tests += 4;
        if (miso[0] !== 1'b0 || oe[0] !== 1'b0 || busy[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL rstmid_pins: miso=%b oe=%b busy=%b required 0 0 0", miso[0], oe[0],
                   busy[0]);
        end
        if (tx_ready[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL rstmid_tx_ready: got %b required 1", tx_ready[0]);
        end
        if (rx_data[0] !== 16'h0000) begin
          n_fail++;
          $display("FAIL rstmid_rx_data: got %h required 0000", rx_data[0]);
        end
        if (rx_valid[0] !== 1'b0 || underrun[0] !== 1'b0 || ferr[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL rstmid_pulses: got %b%b%b required 000", rx_valid[0], underrun[0],
                   ferr[0]);
        end
      end
    join
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    push(0, 16'hC3A5);
    v0 = n_valid[0];
    u0 = n_under[0];
    f0 = n_ferr[0];
    xfer(0, 16'h5A5A, W, rd);
    n_tests += 4;
    if (rd !== 16'hC3A5) begin
      n_fail++;
      $display("FAIL rstmid_next_miso: got %h required c3a5", rd);
    end
    if (rx_data[0] !== 16'h5A5A) begin
      n_fail++;
      $display("FAIL rstmid_next_rx_data: got %h required 5a5a", rx_data[0]);
    end
    if (n_valid[0] - v0 !== 1) begin
      n_fail++;
      $display("FAIL rstmid_next_rx_valid_cycles: got %0d required 1", n_valid[0] - v0);
    end
    if (n_under[0] - u0 !== 0 || n_ferr[0] - f0 !== 0) begin
      n_fail++;
      $display("FAIL rstmid_next_errors: underrun=%0d frame_err=%0d required 0 0",
               n_under[0] - u0, n_ferr[0] - f0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sclk[i]     = (i == 1);
      ss[i]       = 1'b1;
      mosi[i]     = 1'b0;
      tx_valid[i] = 1'b0;
      tx_data[i]  = '0;
    end
    repeat (3) @(negedge clk);
    test_reset();
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    test_mode0();
    test_mode3();
    test_underrun();
    test_abort();
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
